// File: rtl/ram_ctrl_if.sv
// Host-side channels of ram_ctrl: command, write-beat and read-response handshakes.
// The host drives the master modport and the controller takes the slave modport.
interface ram_ctrl_if #(
  parameter int ADDR_WIDE = 9,
  parameter int DATA_WIDE = 32,
  parameter int LEN_W     = 4
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_WIDE-1:0] req_addr;
  logic [LEN_W-1:0]     req_len;
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic [DATA_WIDE-1:0] wdata;
  logic                 rdata_valid;
  logic                 rdata_ready;
  logic [DATA_WIDE-1:0] rdata;
  logic                 rdata_last;
  logic                 busy;

  modport master (
    output req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_len, wdata_valid, wdata, rdata_ready,
    output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy
  );
endinterface

// File: rtl/ram_ctrl.sv
// Burst access controller in front of the single-port ram: sequences host bursts into
// one-cycle wr_en/re_en strobes and owns the write drive of the shared data bus.
module ram_ctrl #(
  parameter int DATA_WIDE  = 32,
  parameter int DEEP       = 512,
  parameter int ADDR_WIDE  = $clog2(DEEP),
  parameter int LEN_W      = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_ctrl_if.slave            bus,
  output logic                 ram_wr_en,
  output logic                 ram_re_en,
  output logic [ADDR_WIDE-1:0] ram_addr,
  inout  wire  [DATA_WIDE-1:0] ram_data_io
);

  // state      | meaning
  // IDLE       | req_ready high, waiting for a command
  // WR_BEAT    | wdata_ready high, each accepted beat becomes one wr_en strobe
  // RD_ISSUE   | one re_en strobe for the current beat address
  // RD_WAIT    | down-count RD_LATENCY, then capture the bus into rdata
  // RD_RESP    | rdata_valid held until the host takes the beat
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_BEAT  = 3'd1;
  localparam logic [2:0] S_RD_ISSUE = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_RD_RESP  = 3'd4;

  localparam logic [2:0]           LAT      = 3'(RD_LATENCY);
  localparam logic [ADDR_WIDE-1:0] ADDR_TOP = ADDR_WIDE'(DEEP - 1);

  logic [2:0]           state_q,    state_d;
  logic                 rdy_q,      rdy_d;
  logic [ADDR_WIDE-1:0] addr_q,     addr_d;
  logic [LEN_W-1:0]     len_q,      len_d;
  logic [LEN_W-1:0]     beat_q,     beat_d;
  logic [2:0]           wait_q,     wait_d;
  logic                 wr_en_q,    wr_en_d;
  logic                 re_en_q,    re_en_d;
  logic [ADDR_WIDE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDE-1:0] wdata_q,    wdata_d;
  logic [DATA_WIDE-1:0] rdata_q,    rdata_d;
  logic                 rlast_q,    rlast_d;
  logic [ADDR_WIDE-1:0] addr_nxt;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  assign addr_nxt = (addr_q == ADDR_TOP) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    wr_en_d    = 1'b0;
    re_en_d    = 1'b0;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && rdy_q) begin
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          beat_d  = '0;
          state_d = bus.req_wr ? S_WR_BEAT : S_RD_ISSUE;
        end
      end
      S_WR_BEAT: begin
        if (bus.wdata_valid) begin
          wr_en_d    = 1'b1;
          ram_addr_d = addr_q;
          wdata_d    = bus.wdata;
          addr_d     = addr_nxt;
          beat_d     = beat_q + 1'b1;
          if (beat_q == len_q) state_d = S_IDLE;
        end
      end
      S_RD_ISSUE: begin
        re_en_d    = 1'b1;
        ram_addr_d = addr_q;
        addr_d     = addr_nxt;
        wait_d     = LAT;
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_q == 3'd0) begin
          rdata_d = ram_data_io;
          rlast_d = (beat_q == len_q);
          state_d = S_RD_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      S_RD_RESP: begin
        if (bus.rdata_ready) begin
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is registered so it stays low through reset and rises one clock later.
  assign rdy_d = (state_d == S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rdy_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      wait_q     <= '0;
      wr_en_q    <= 1'b0;
      re_en_q    <= 1'b0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      wr_en_q    <= wr_en_d;
      re_en_q    <= re_en_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
    end
  end

  assign bus.req_ready   = rdy_q;
  assign bus.wdata_ready = (state_q == S_WR_BEAT);
  assign bus.rdata_valid = (state_q == S_RD_RESP);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_last  = rlast_q;
  assign bus.busy        = (state_q != S_IDLE);

  assign ram_wr_en   = wr_en_q;
  assign ram_re_en   = re_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_io = wr_en_q ? wdata_q : {DATA_WIDE{1'bz}};

endmodule
